// File: rtl/channel_allocator_pkg.sv
// -----------------------------------------------------------------------------
// channel_allocator_pkg
//
// Shared constants and types for the channel allocator and the memory port
// multiplexer it shares with later channel send/receive stages.
//
//   ADDRESS_BITS / DATA_BITS : default RAM address and word widths
//   RAM_READ / RAM_WRITE     : encodings of the RAM readWriteMode signal
//   CHANNEL_EMPTY            : default marker word for an empty channel cell
//   alloc_state_t            : allocator controller states (3-bit encoding)
//   port_owner_t             : which client currently drives the RAM port
// -----------------------------------------------------------------------------
package channel_allocator_pkg;

  localparam int ADDRESS_BITS = 8;
  localparam int DATA_BITS    = 16;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  localparam logic [DATA_BITS-1:0] CHANNEL_EMPTY = {DATA_BITS{1'b1}};

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ALLOC_WAIT  = 3'd1,
    INIT_W1     = 3'd2,
    INIT_W2     = 3'd3,
    DESTROY_RD  = 3'd4,
    DESTROY_CHK = 3'd5,
    FREE_ISSUE  = 3'd6,
    FREE_WAIT   = 3'd7
  } alloc_state_t;

  // OWNER_NONE parks the port in read mode with don't-care address/data.
  typedef enum logic [1:0] {
    OWNER_NONE   = 2'd0,
    OWNER_CLIENT = 2'd1,
    OWNER_HEAP   = 2'd2
  } port_owner_t;

endpackage

// File: rtl/channel_allocator_if.sv
// -----------------------------------------------------------------------------
// channel_allocator_if
//
// Bundles everything the channel allocator talks to apart from clk/reset:
//   processor side : create, destroy, destroyAddress -> finished, error,
//                    channelAddress
//   heap side      : heapAlloc, heapFree, heapFreeAddress -> heapAllocAddress,
//                    heapFinished, plus the heap's own memory request
//                    (heapMemAddress, heapMemReadWriteMode, heapMemDataIn)
//   RAM side       : address, readWriteMode, dataIn -> dataOut (synchronous,
//                    valid one cycle after address)
//
// Modports:
//   slave  : the channel allocator itself
//   master : its environment (processor, heap and RAM together)
// -----------------------------------------------------------------------------
interface channel_allocator_if
  import channel_allocator_pkg::*;
#(
  parameter int addrBits = ADDRESS_BITS,
  parameter int dataBits = DATA_BITS
) ();

  // Processor request / completion
  logic                create;
  logic                destroy;
  logic [addrBits-1:0] destroyAddress;
  logic                finished;
  logic                error;
  logic [addrBits-1:0] channelAddress;

  // Heap handshake
  logic                heapAlloc;
  logic                heapFree;
  logic [addrBits-1:0] heapFreeAddress;
  logic [addrBits-1:0] heapAllocAddress;
  logic                heapFinished;

  // Heap memory request, forwarded to the RAM while the heap owns it
  logic [addrBits-1:0] heapMemAddress;
  logic                heapMemReadWriteMode;
  logic [dataBits-1:0] heapMemDataIn;

  // The single RAM port
  logic [addrBits-1:0] address;
  logic                readWriteMode;
  logic [dataBits-1:0] dataIn;
  logic [dataBits-1:0] dataOut;

  modport slave (
    input  create, destroy, destroyAddress,
    output finished, error, channelAddress,
    output heapAlloc, heapFree, heapFreeAddress,
    input  heapAllocAddress, heapFinished,
    input  heapMemAddress, heapMemReadWriteMode, heapMemDataIn,
    output address, readWriteMode, dataIn,
    input  dataOut
  );

  modport master (
    output create, destroy, destroyAddress,
    input  finished, error, channelAddress,
    input  heapAlloc, heapFree, heapFreeAddress,
    output heapAllocAddress, heapFinished,
    output heapMemAddress, heapMemReadWriteMode, heapMemDataIn,
    input  address, readWriteMode, dataIn,
    output dataOut
  );

endinterface

// File: rtl/channel_allocator_memory_port_mux.sv
// -----------------------------------------------------------------------------
// memory_port_mux
//
// Combinational 2-owner to 1 RAM port multiplexer.
//
// Ports:
//   select              in  port_owner_t  which owner drives the RAM port
//   client_address/_rw/_data  in          request from the local controller
//   heap_address/_rw/_data    in          request from the heap
//   address, readWriteMode, dataIn  out   the shared RAM port
//
// With no owner the port is held in read mode so nothing is ever written by
// accident; address and data are left as don't-care.
// -----------------------------------------------------------------------------
module memory_port_mux
  import channel_allocator_pkg::*;
#(
  parameter int addrBits = ADDRESS_BITS,
  parameter int dataBits = DATA_BITS
) (
  input  port_owner_t         select,
  input  logic [addrBits-1:0] client_address,
  input  logic                client_rw,
  input  logic [dataBits-1:0] client_data,
  input  logic [addrBits-1:0] heap_address,
  input  logic                heap_rw,
  input  logic [dataBits-1:0] heap_data,
  output logic [addrBits-1:0] address,
  output logic                readWriteMode,
  output logic [dataBits-1:0] dataIn
);

  always_comb begin
    address       = 'x;
    readWriteMode = RAM_READ;
    dataIn        = 'x;
    case (select)
      OWNER_CLIENT: begin
        address       = client_address;
        readWriteMode = client_rw;
        dataIn        = client_data;
      end
      OWNER_HEAP: begin
        address       = heap_address;
        readWriteMode = heap_rw;
        dataIn        = heap_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/channel_allocator.sv
// -----------------------------------------------------------------------------
// channel_allocator
//
// Turns processor channel create/destroy requests into heap alloc/free
// pulses. A created channel cell is initialised to emptyWord; a destroy is
// refused (error=1) when the cell still holds a value. The block owns the
// single RAM port and lends it to the heap while the heap is working.
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-low reset (also resets the heap)
//   bus    channel_allocator_if.slave: processor, heap and RAM signals
//
// Timing, request in cycle 0:
//   create (fresh heap region) finished in 4, (heap reuse) in 5,
//   destroy finished in 6, refused destroy finished in 3.
// -----------------------------------------------------------------------------
module channel_allocator
  import channel_allocator_pkg::*;
#(
  parameter int                  addrBits  = ADDRESS_BITS,
  parameter int                  dataBits  = DATA_BITS,
  parameter logic [dataBits-1:0] emptyWord = CHANNEL_EMPTY
) (
  input logic               clk,
  input logic               reset,
  channel_allocator_if.slave bus
);

  alloc_state_t        state;
  alloc_state_t        state_next;

  // One address register serves both flows: the freshly allocated cell
  // during init, and the channel being destroyed through free.
  logic [addrBits-1:0] latched_address;
  logic [addrBits-1:0] channel_address_q;
  logic                finished_q;
  logic                error_q;

  logic                finish_set;
  logic                error_set;
  logic                load_destroy;
  logic                load_alloc;
  logic                publish_channel;
  logic                heap_alloc;
  logic                heap_free;
  logic                client_rw;
  port_owner_t         owner;

  logic [addrBits-1:0] ram_address;
  logic                ram_rw;
  logic [dataBits-1:0] ram_data;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      latched_address   <= '0;
      channel_address_q <= '0;
      finished_q        <= 1'b0;
      error_q           <= 1'b0;
    end else begin
      state      <= state_next;
      finished_q <= finish_set;
      error_q    <= error_set;
      if (load_destroy) begin
        latched_address <= bus.destroyAddress;
      end else if (load_alloc) begin
        latched_address <= bus.heapAllocAddress;
      end
      if (publish_channel) begin
        channel_address_q <= latched_address;
      end
    end
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_next      = state;
    heap_alloc      = 1'b0;
    heap_free       = 1'b0;
    owner           = OWNER_NONE;
    client_rw       = RAM_READ;
    finish_set      = 1'b0;
    error_set       = 1'b0;
    load_destroy    = 1'b0;
    load_alloc      = 1'b0;
    publish_channel = 1'b0;

    case (state)
      IDLE: begin
        // create wins when both arrive together; destroy is dropped.
        if (bus.create) begin
          heap_alloc = 1'b1;
          owner      = OWNER_HEAP;
          state_next = ALLOC_WAIT;
        end else if (bus.destroy) begin
          load_destroy = 1'b1;
          state_next   = DESTROY_RD;
        end
      end

      ALLOC_WAIT: begin
        owner = OWNER_HEAP;
        if (bus.heapFinished) begin
          load_alloc = 1'b1;
          state_next = INIT_W1;
        end
      end

      // The empty marker is written on two consecutive cycles with a
      // constant address and word.
      INIT_W1: begin
        owner      = OWNER_CLIENT;
        client_rw  = RAM_WRITE;
        state_next = INIT_W2;
      end

      INIT_W2: begin
        owner           = OWNER_CLIENT;
        client_rw       = RAM_WRITE;
        finish_set      = 1'b1;
        publish_channel = 1'b1;
        state_next      = IDLE;
      end

      DESTROY_RD: begin
        owner      = OWNER_CLIENT;
        state_next = DESTROY_CHK;
      end

      // Address is still presented here; dataOut now holds the cell.
      DESTROY_CHK: begin
        owner = OWNER_CLIENT;
        if (bus.dataOut == emptyWord) begin
          state_next = FREE_ISSUE;
        end else begin
          finish_set = 1'b1;
          error_set  = 1'b1;
          state_next = IDLE;
        end
      end

      FREE_ISSUE: begin
        owner      = OWNER_HEAP;
        heap_free  = 1'b1;
        state_next = FREE_WAIT;
      end

      FREE_WAIT: begin
        owner = OWNER_HEAP;
        if (bus.heapFinished) begin
          finish_set = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  memory_port_mux #(
    .addrBits (addrBits),
    .dataBits (dataBits)
  ) u_port_mux (
    .select         (owner),
    .client_address (latched_address),
    .client_rw      (client_rw),
    .client_data    (emptyWord),
    .heap_address   (bus.heapMemAddress),
    .heap_rw        (bus.heapMemReadWriteMode),
    .heap_data      (bus.heapMemDataIn),
    .address        (ram_address),
    .readWriteMode  (ram_rw),
    .dataIn         (ram_data)
  );

  assign bus.address       = ram_address;
  assign bus.readWriteMode = ram_rw;
  assign bus.dataIn        = ram_data;

  assign bus.heapAlloc       = heap_alloc;
  assign bus.heapFree        = heap_free;
  // The heap re-reads the free address while it works, so it stays on the
  // latched value for the whole of FREE_WAIT.
  assign bus.heapFreeAddress = latched_address;

  assign bus.finished       = finished_q;
  assign bus.error          = error_q;
  assign bus.channelAddress = channel_address_q;

endmodule

// File: tb/tb_channel_allocator.sv
// -----------------------------------------------------------------------------
// tb_channel_allocator
//
// Directed bench for channel_allocator with a small heap model
// (base 0x10, max 0x12, fresh allocation answers next cycle, reuse and free
// answer one cycle later) and a synchronous RAM model. The heap records its
// most recent free in RAM word 0x01 through the shared port.
// -----------------------------------------------------------------------------
module tb_channel_allocator;
  import channel_allocator_pkg::*;

  localparam int AW = ADDRESS_BITS;
  localparam int DW = DATA_BITS;
  localparam logic [AW-1:0] HEAP_BASE = 8'h10;
  localparam logic [AW-1:0] HEAP_MAX  = 8'h12;
  localparam logic [AW-1:0] HEAP_META = 8'h01;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  channel_allocator_if #(.addrBits(AW), .dataBits(DW)) bus ();

  channel_allocator #(
    .addrBits  (AW),
    .dataBits  (DW),
    .emptyWord (16'hFFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // ---------------- RAM model with a backdoor write ----------------
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          bd_en   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_en) ram[bd_addr] <= bd_data;
    else if (bus.readWriteMode == RAM_WRITE) ram[bus.address] <= bus.dataIn;
    bus.dataOut <= ram[bus.address];
  end

  // ---------------- heap model ----------------
  logic [AW-1:0] heap_next;
  logic [AW-1:0] free_list [$];
  logic          heap_pending;
  logic          heap_freeing;
  logic [AW-1:0] heap_result;
  logic [AW-1:0] heap_last_freed;

  always @(posedge clk) begin
    if (!reset) begin
      heap_next            <= HEAP_BASE;
      free_list.delete();
      heap_pending         <= 1'b0;
      heap_freeing         <= 1'b0;
      heap_result          <= '0;
      heap_last_freed      <= '0;
      bus.heapFinished     <= 1'b0;
      bus.heapAllocAddress <= '0;
    end else begin
      bus.heapFinished <= 1'b0;
      if (heap_pending) begin
        bus.heapFinished     <= 1'b1;
        bus.heapAllocAddress <= heap_result;
        heap_pending         <= 1'b0;
        heap_freeing         <= 1'b0;
      end
      if (bus.heapAlloc) begin
        if (heap_next <= HEAP_MAX) begin
          bus.heapAllocAddress <= heap_next;
          bus.heapFinished     <= 1'b1;
          heap_next            <= heap_next + 8'd1;
        end else if (free_list.size() > 0) begin
          heap_result  <= free_list.pop_front();
          heap_pending <= 1'b1;
        end
      end
      if (bus.heapFree) begin
        free_list.push_back(bus.heapFreeAddress);
        heap_last_freed <= bus.heapFreeAddress;
        heap_pending    <= 1'b1;
        heap_freeing    <= 1'b1;
      end
    end
  end

  assign bus.heapMemAddress       = HEAP_META;
  assign bus.heapMemReadWriteMode = heap_freeing ? RAM_WRITE : RAM_READ;
  assign bus.heapMemDataIn        = DW'(heap_last_freed);

  // ---------------- pulse monitor ----------------
  int            alloc_hi = 0;
  int            free_hi  = 0;
  int            hold_err = 0;
  logic          free_active = 1'b0;
  logic [AW-1:0] free_addr_seen = '0;

  always @(negedge clk) begin
    if (bus.heapAlloc) alloc_hi++;
    if (free_active && bus.heapFreeAddress !== free_addr_seen) hold_err++;
    if (bus.heapFinished) free_active = 1'b0;
    if (bus.heapFree) begin
      free_hi++;
      free_addr_seen = bus.heapFreeAddress;
      free_active    = 1'b1;
    end
  end

  // Drives one request in cycle 0 and returns the cycle number in which
  // finished is seen (-1 on timeout). A stray create is pulsed in cycle
  // poke_cycle when that is non-zero. Returns at the negedge of the
  // finished cycle so the caller can sample the completion outputs.
  task automatic run_op(input logic do_create, input logic do_destroy,
                        input logic [AW-1:0] daddr, input int poke_cycle,
                        output int latency);
    @(posedge clk); #1;
    bus.create         = do_create;
    bus.destroy        = do_destroy;
    bus.destroyAddress = daddr;
    latency = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      bus.create  = (c == poke_cycle);
      bus.destroy = 1'b0;
      @(negedge clk);
      if (bus.finished) begin
        latency = c;
        break;
      end
    end
    bus.create = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected $finish earlier");
    $fatal(1);
  end

  int lat;
  int a0, f0;

  initial begin
    bus.create         = 1'b0;
    bus.destroy        = 1'b0;
    bus.destroyAddress = '0;

    // ---- reset ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_finished", bus.finished, 1'b0);
    check("reset_error", bus.error, 1'b0);
    check("reset_channel", bus.channelAddress, 8'h00);
    check("reset_heap_alloc", bus.heapAlloc, 1'b0);
    check("reset_heap_free", bus.heapFree, 1'b0);
    check("reset_rw", bus.readWriteMode, RAM_READ);
    reset = 1'b1;

    // ---- create #1: fresh region ----
    a0 = alloc_hi; f0 = free_hi;
    run_op(1'b1, 1'b0, 8'h00, 0, lat);
    check("create1_latency", lat, 4);
    check("create1_alloc_pulses", alloc_hi - a0, 1);
    check("create1_channel", bus.channelAddress, 8'h10);
    check("create1_error", bus.error, 1'b0);
    check("create1_ram", ram[8'h10], 16'hFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    check("create1_finished_one_cycle", bus.finished, 1'b0);

    // ---- create #2 with a stray create during INIT_W1 ----
    a0 = alloc_hi;
    run_op(1'b1, 1'b0, 8'h00, 2, lat);
    check("create2_latency", lat, 4);
    check("create2_alloc_pulses", alloc_hi - a0, 1);
    check("create2_channel", bus.channelAddress, 8'h11);
    check("create2_ram", ram[8'h11], 16'hFFFF);

    // ---- destroy 0x11 (empty cell) ----
    a0 = alloc_hi; f0 = free_hi;
    run_op(1'b0, 1'b1, 8'h11, 0, lat);
    check("destroy11_latency", lat, 6);
    check("destroy11_error", bus.error, 1'b0);
    check("destroy11_free_pulses", free_hi - f0, 1);
    check("destroy11_free_addr", free_addr_seen, 8'h11);
    check("destroy11_free_addr_held", hold_err, 0);
    check("destroy11_no_alloc", alloc_hi - a0, 0);
    check("destroy11_heap_ram_write", ram[HEAP_META], 16'h0011);
    check("destroy11_channel_kept", bus.channelAddress, 8'h11);

    // ---- create and destroy together: create wins ----
    a0 = alloc_hi; f0 = free_hi;
    run_op(1'b1, 1'b1, 8'h10, 0, lat);
    check("both_latency", lat, 4);
    check("both_channel", bus.channelAddress, 8'h12);
    check("both_alloc_pulses", alloc_hi - a0, 1);
    check("both_no_free", free_hi - f0, 0);

    // ---- create via heap reuse path ----
    run_op(1'b1, 1'b0, 8'h00, 0, lat);
    check("reuse_latency", lat, 5);
    check("reuse_channel", bus.channelAddress, 8'h11);
    check("reuse_error", bus.error, 1'b0);

    // ---- refused destroy of 0x10 holding 0x0042 ----
    @(posedge clk); #1;
    bd_en = 1'b1; bd_addr = 8'h10; bd_data = 16'h0042;
    @(posedge clk); #1;
    bd_en = 1'b0;
    a0 = alloc_hi; f0 = free_hi;
    run_op(1'b0, 1'b1, 8'h10, 0, lat);
    check("refuse_latency", lat, 3);
    check("refuse_error", bus.error, 1'b1);
    check("refuse_no_free", free_hi - f0, 0);
    check("refuse_no_alloc", alloc_hi - a0, 0);
    check("refuse_ram_kept", ram[8'h10], 16'h0042);
    check("refuse_channel_kept", bus.channelAddress, 8'h11);

    // ---- destroy 0x12 so the next create takes the reuse path ----
    f0 = free_hi;
    run_op(1'b0, 1'b1, 8'h12, 0, lat);
    check("destroy12_latency", lat, 6);
    check("destroy12_error", bus.error, 1'b0);
    check("destroy12_free_addr", free_addr_seen, 8'h12);

    // ---- reset asserted in INIT_W1 ----
    @(posedge clk); #1;
    bus.create = 1'b1;                 // cycle 0
    @(posedge clk); #1;
    bus.create = 1'b0;                 // cycle 1: ALLOC_WAIT
    @(posedge clk); #1;                // cycle 2: heap answers
    @(posedge clk); #1;                // cycle 3: INIT_W1
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_init_w1", 32'(dut.state), 32'(INIT_W1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_state_idle", 32'(dut.state), 32'(IDLE));
    check("abort_finished", bus.finished, 1'b0);
    check("abort_channel", bus.channelAddress, 8'h00);

    // ---- heap was reset too: create starts again at the base ----
    run_op(1'b1, 1'b0, 8'h00, 0, lat);
    check("post_reset_latency", lat, 4);
    check("post_reset_channel", bus.channelAddress, 8'h10);
    check("post_reset_error", bus.error, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/channel_allocator.md
Name: channel_allocator

Overview:
- Upstream client of the heap allocator. Turns processor-level channel create/destroy requests into heap alloc/free pulses.
- On create: initialises the new channel cell in RAM to the empty marker.
- On destroy: refuses to free a channel cell that still holds a value.
- Owns the single RAM port and muxes the heap's memory port through it while the heap is busy.

Parameters:
- addrBits, `ADDRESS_BITS, RAM address width; heap addresses share this width.
- dataBits, `DATA_BITS, RAM word width.
- emptyWord, {dataBits{1'b1}}, value marking a channel cell as empty.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- create  in  1  single-cycle request: allocate a channel
- destroy  in  1  single-cycle request: free channel at destroyAddress
- destroyAddress  in  addrBits  channel to free; held stable until finished
- finished  out  1  one-cycle completion pulse
- error  out  1  valid with finished; 1 = destroy refused (cell not empty)
- channelAddress  out  addrBits  allocated channel; valid from the create's finished pulse until the next create completes
- heapAlloc  out  1  alloc pulse to heap
- heapFree  out  1  free pulse to heap
- heapFreeAddress  out  addrBits  address to free
- heapAllocAddress  in  addrBits  heap result; valid when heapFinished=1
- heapFinished  in  1  heap completion pulse
- heapMemAddress, heapMemReadWriteMode, heapMemDataIn  in  addrBits/1/dataBits  heap's memory request
- address  out  addrBits  RAM address
- readWriteMode  out  1  `RAM_READ / `RAM_WRITE
- dataIn  out  dataBits  RAM write data
- dataOut  in  dataBits  RAM read data; synchronous, valid one cycle after address

Behaviour:
- Reset (reset=0 at a posedge), regardless of state:
  - state=IDLE; finished=0, error=0, channelAddress=0, latched address=0.
  - A heap operation in flight is abandoned; the heap is reset by the same signal.
- Requests are sampled only in IDLE and ignored in all other states. create and destroy together: create wins, destroy is dropped.
- heapAlloc and heapFree are each high for exactly one cycle per operation. The heap must never see a level.
- RAM mux:
  - The heap owns the port (address/readWriteMode/dataIn = heapMem*) in the IDLE cycle that issues heapAlloc or heapFree, and in ALLOC_WAIT and FREE_WAIT.
  - This block owns the port in INIT_W1, INIT_W2, DESTROY_RD and DESTROY_CHK.
  - Otherwise: readWriteMode=`RAM_READ, address and dataIn = x.
- Writes are held for two consecutive cycles with constant address and data.

State machine:
- IDLE:
  - create → heapAlloc=1 → ALLOC_WAIT.
  - destroy → latch destroyAddress → DESTROY_RD.
- ALLOC_WAIT: heapAlloc=0. On heapFinished, latch heapAllocAddress → INIT_W1.
- INIT_W1 and INIT_W2: write emptyWord to the latched address. INIT_W2 → IDLE, with registered finished=1, error=0 and channelAddress updated in the following cycle.
- DESTROY_RD: read from the latched address → DESTROY_CHK (address held).
- DESTROY_CHK:
  - dataOut==emptyWord → FREE_ISSUE.
  - Otherwise → IDLE with finished=1, error=1. No heap activity.
- FREE_ISSUE: heapFree=1, heapFreeAddress=latched address, heap owns RAM → FREE_WAIT.
- FREE_WAIT: heapFreeAddress held. On heapFinished → IDLE with finished=1, error=0.

Latency (request in cycle 0):
- create, heap fresh region: finished in cycle 4.
- create, heap reuse path: finished in cycle 5.
- destroy: finished in cycle 6.
- refused destroy: finished in cycle 3.

Other rules:
- heapFreeAddress is held through FREE_WAIT because the heap re-reads it.
- Heap exhaustion is not detected here.

Decomposition:
- `RAM_READ, `RAM_WRITE, `ADDRESS_BITS and `DATA_BITS come from defaults.vh.
- Add `CHANNEL_EMPTY there as the shared default for emptyWord.
- State encodings are local 3-bit localparams.
- Sub-module: memory_port_mux (combinational, 2 owners → 1 RAM port, with a select input). It will be reused by later channel send/receive stages.

Test Plan:
- Bench: heap (heapBase=0x10, heapMax=0x12) + synchronous RAM model.
- Create after reset → heapAlloc pulses exactly one cycle; finished in cycle 4; channelAddress=0x10; RAM[0x10]=0xFFFF.
- Two creates back-to-back → 0x10 then 0x11. A create pulsed during the first operation is ignored.
- Destroy 0x11 with RAM[0x11]=0xFFFF → heapFree pulse with heapFreeAddress=0x11; finished, error=0. Then fill the heap to 0x12; the next create returns 0x11 via the reuse path, with finished in cycle 5.
- Destroy 0x10 with RAM[0x10]=0x0042 → finished in cycle 3, error=1. heapFree never asserted; RAM unchanged.
- create and destroy in the same cycle → only the alloc occurs; channelAddress=next free address; no free issued.
- reset=0 asserted in INIT_W1 → next cycle state=IDLE, finished=0. A following create completes normally.
